uart_tx_word: RTL and testbench

Parametrised UART transmitter for the FPU serial link that sends a multi-byte word (result, status) as consecutive 8N1/8E1/8O1/8N2 frames, least-significant byte first. It generates its own bit timing from the system clock and accepts words over a valid/ready handshake. It raises a one-cycle completion pulse so the result-return controller can sequence the next word. It replaces fixed 2-byte transmit FSMs that need external bit/byte counters, and drives `tx` from a register rather than from decoded state.

---
 rtl/uart_tx_word.sv | 154 +++++++++++++++
 tb/tb_uart_tx_word.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word.sv
// UART transmitter for multi-byte words: 8N1/8E1/8O1/8N2 frames, LSB byte first.
// Baud timing is generated internally; the serial line is driven from a register.
module uart_tx_word #(
  parameter int unsigned WORD_BYTES   = 2,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_valid,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  output logic                    tx_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    word_done
);

  if (WORD_BYTES < 1) begin : g_bad_wb
    $error("uart_tx_word: WORD_BYTES must be >= 1");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_word: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_tx_word: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW =
    (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned DW = 8 * WORD_BYTES;

  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end   = (baud_q == BAUD_MAX);
  assign tx        = tx_q;
  assign tx_ready  = (state_q == S_IDLE) && rst;
  assign busy      = (state_q != S_IDLE);
  assign word_done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    buf_d   = buf_q;
    if (state_q != S_IDLE && state_q != S_DONE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_START;
          buf_d   = tx_data;
          byte_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else if (byte_q == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            // Next byte moves into the low lane; no idle gap.
            state_d = S_START;
            byte_d  = byte_q + 1'b1;
            buf_d   = buf_q >> 8;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the coming cycle, decoded from next-state values.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = buf_d[bit_d];
      S_PARITY: tx_d = (^buf_d[7:0]) ^ ODD;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      buf_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word: three configurations checked cycle by cycle
// against a frame-level model of the serial line.
module tb_uart_tx_word;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        valid [3];
  logic [15:0] data  [3];
  logic        rdy   [3];
  logic        txo   [3];
  logic        bsy   [3];
  logic        wd    [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_word #(
    .WORD_BYTES(2), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) d0 (
    .clk(clk), .rst(rst),
    .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(rdy[0]), .tx(txo[0]),
    .busy(bsy[0]), .word_done(wd[0])
  );

  uart_tx_word #(
    .WORD_BYTES(1), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) d1 (
    .clk(clk), .rst(rst),
    .tx_valid(valid[1]), .tx_data(data[1][7:0]),
    .tx_ready(rdy[1]), .tx(txo[1]),
    .busy(bsy[1]), .word_done(wd[1])
  );

  uart_tx_word #(
    .WORD_BYTES(1), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) d2 (
    .clk(clk), .rst(rst),
    .tx_valid(valid[2]), .tx_data(data[2][7:0]),
    .tx_ready(rdy[2]), .tx(txo[2]),
    .busy(bsy[2]), .word_done(wd[2])
  );

  function automatic int nb_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int pe_of(int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int po_of(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int sb_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int frame_of(int k);
    return 10 + pe_of(k) + sb_of(k) - 1;
  endfunction

  function automatic int wlen_of(int k);
    return nb_of(k) * frame_of(k) * CPB;
  endfunction

  // Line level in cycle c (1-based) after the accept edge.
  function automatic logic exp_tx(int k, logic [15:0] w, int c);
    int f;
    int bn;
    int by;
    int pos;
    logic [15:0] s;
    logic [7:0] b;
    f   = frame_of(k);
    bn  = (c - 1) / CPB;
    by  = bn / f;
    pos = bn % f;
    s   = w >> (8 * by);
    b   = s[7:0];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pe_of(k) == 1 && pos == 9)
      return (^b) ^ logic'(po_of(k));
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 drop valid after accept, 1 hold valid throughout,
  // 2 raise valid in the DONE cycle.  nxt is the data driven after accept.
  task automatic xfer(int k, logic [15:0] w, int mode,
                      bit scramble, logic [15:0] nxt);
    int n;
    n = wlen_of(k);
    valid[k] = 1'b1;
    data[k]  = w;
    chk($sformatf("d%0d ready_pre", k), rdy[k], 1'b1);
    step();
    valid[k] = (mode == 1);
    data[k]  = nxt;
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("d%0d w%h tx c%0d", k, w, c),
          txo[k], exp_tx(k, w, c));
      if (c == 1 || c == n || mode == 1) begin
        chk($sformatf("d%0d busy c%0d", k, c), bsy[k], 1'b1);
        chk($sformatf("d%0d ready c%0d", k, c), rdy[k], 1'b0);
        chk($sformatf("d%0d done c%0d", k, c), wd[k], 1'b0);
      end
      if (scramble) data[k] = 16'($urandom);
      step();
    end
    chk($sformatf("d%0d done pulse", k), wd[k], 1'b1);
    chk($sformatf("d%0d tx in done", k), txo[k], 1'b1);
    chk($sformatf("d%0d ready in done", k), rdy[k], 1'b0);
    chk($sformatf("d%0d busy in done", k), bsy[k], 1'b1);
    if (mode == 2) begin
      valid[k] = 1'b1;
      data[k]  = nxt;
    end
    step();
    chk($sformatf("d%0d done cleared", k), wd[k], 1'b0);
    chk($sformatf("d%0d tx idle", k), txo[k], 1'b1);
    chk($sformatf("d%0d ready idle", k), rdy[k], 1'b1);
    chk($sformatf("d%0d busy idle", k), bsy[k], 1'b0);
  endtask

  logic [15:0] w;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      data[k]  = '0;
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst d%0d tx", k), txo[k], 1'b1);
      chk($sformatf("rst d%0d busy", k), bsy[k], 1'b0);
      chk($sformatf("rst d%0d done", k), wd[k], 1'b0);
      chk($sformatf("rst d%0d ready", k), rdy[k], 1'b0);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("rel d%0d ready", k), rdy[k], 1'b1);
    step();

    xfer(0, 16'hA53C, 0, 1'b0, 16'h0000);
    xfer(1, 16'h0007, 0, 1'b0, 16'h0000);
    xfer(2, 16'h0007, 0, 1'b0, 16'h0000);

    for (int i = 0; i < 3; i++)
      xfer(0, 16'($urandom), 0, 1'b1, 16'($urandom));
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom_range(0, 255));
      xfer(1, w, 0, 1'b1, 16'($urandom));
      w = 16'($urandom_range(0, 255));
      xfer(2, w, 0, 1'b1, 16'($urandom));
    end

    xfer(0, 16'h0001, 1, 1'b0, 16'h8000);
    xfer(0, 16'h8000, 0, 1'b0, 16'h0000);

    xfer(0, 16'h5A0F, 2, 1'b0, 16'hC3E1);
    xfer(0, 16'hC3E1, 0, 1'b0, 16'h0000);

    w = 16'hF00D;
    n = wlen_of(0);
    valid[0] = 1'b1;
    data[0]  = w;
    step();
    valid[0] = 1'b0;
    for (int c = 1; c <= 58; c++) begin
      chk($sformatf("pre-rst tx c%0d", c), txo[0], exp_tx(0, w, c));
      if (c == 58) rst = 1'b0;
      step();
    end
    chk("mid-rst tx", txo[0], 1'b1);
    chk("mid-rst ready", rdy[0], 1'b0);
    chk("mid-rst busy", bsy[0], 1'b0);
    chk("mid-rst done", wd[0], 1'b0);
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (wd[0] !== 1'b0 || txo[0] !== 1'b1) begin
        chk($sformatf("post-rst quiet c%0d", c), wd[0], 1'b0);
        chk($sformatf("post-rst line c%0d", c), txo[0], 1'b1);
      end
      step();
    end
    chk("post-rst done", wd[0], 1'b0);
    chk("post-rst line", txo[0], 1'b1);
    xfer(0, 16'h3C96, 0, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
